// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one 64-bit RAM port between instruction fetch (I) and load/store (D),
// converts byte addresses to word indices, sequences read latency and returns valid/ready responses.
// Build option ARB_ROUND_ROBIN_EN: conflicts alternate between requesters instead of fixed
// D priority with a starvation guard for I.
module ram_arbiter #(
    parameter logic [63:0] RAM_BASE = 64'h0000_0000_8000_0000,
    parameter int RAM_LAT = 1
`ifndef ARB_ROUND_ROBIN_EN
    ,parameter int STARVE_MAX = 8
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req_valid,
    output logic        i_req_ready,
    input  logic [63:0] i_addr,
    output logic        i_resp_valid,
    input  logic        i_resp_ready,
    output logic [31:0] i_inst,
    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic        d_we,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    input  logic [63:0] d_wmask,
    output logic        d_resp_valid,
    input  logic        d_resp_ready,
    output logic [63:0] d_rdata,
    output logic [63:0] mem_addr,
    output logic        mem_r_ena,
    output logic        mem_w_ena,
    output logic [63:0] mem_w_data,
    output logic [63:0] mem_w_mask,
    input  logic [63:0] mem_r_data
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state, state_nxt;
    logic [1:0] lat_cnt;
    logic owner_d;
    logic inst_hi;
    logic [63:0] resp_q;
    logic idle, grant_i, grant_d, i_wins, resp_hs;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_d;
    assign i_wins = last_d;
    // Remember who won last so the next conflict goes to the other requester.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_d <= 1'b0;
        else if (grant_i || grant_d) last_d <= grant_d;
    end
`else
    localparam int SW = $clog2(STARVE_MAX + 1);
    logic [SW-1:0] starve_cnt;
    assign i_wins = starve_cnt >= SW'(STARVE_MAX);
    // Count D grants that passed over a waiting fetch; any fetch grant clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) starve_cnt <= '0;
        else if (grant_i) starve_cnt <= '0;
        else if (grant_d && i_req_valid) starve_cnt <= starve_cnt + 1'b1;
    end
`endif

    assign i_req_ready  = grant_i;
    assign d_req_ready  = grant_d;
    assign i_resp_valid = state == RESP && !owner_d;
    assign d_resp_valid = state == RESP && owner_d;
    assign i_inst       = inst_hi ? resp_q[63:32] : resp_q[31:0];
    assign d_rdata      = resp_q;
    assign resp_hs      = owner_d ? d_resp_ready : i_resp_ready;

    // Grant in IDLE, drive the granted op onto the RAM port, and decode the next state.
    always_comb begin
        idle       = rst_n && state == IDLE;
        grant_d    = idle && d_req_valid && !(i_req_valid && i_wins);
        grant_i    = idle && i_req_valid && !grant_d;
        mem_addr   = (grant_i || grant_d) ? ((grant_d ? d_addr : i_addr) - RAM_BASE) >> 3 : '0;
        mem_w_ena  = grant_d && d_we;
        mem_r_ena  = grant_i || (grant_d && !d_we);
        mem_w_data = mem_w_ena ? d_wdata : '0;
        mem_w_mask = mem_w_ena ? d_wmask : '0;
        state_nxt  = mem_w_ena ? RESP :
                     mem_r_ena ? WAIT :
                     (state == WAIT && lat_cnt == 2'd0) ? RESP :
                     (state == RESP && resp_hs) ? IDLE : state;
    end

    // State, transaction owner, latency countdown and the response register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            lat_cnt <= 2'd0;
            owner_d <= 1'b0;
            inst_hi <= 1'b0;
            resp_q  <= '0;
        end else begin
            state <= state_nxt;
            if (grant_i || grant_d) begin
                owner_d <= grant_d;
                inst_hi <= grant_i && i_addr[2];
                lat_cnt <= 2'(RAM_LAT - 1);
            end
            if (mem_w_ena) resp_q <= '0;
            if (state == WAIT) begin
                if (lat_cnt == 2'd0) resp_q <= mem_r_data;
                else lat_cnt <= lat_cnt - 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: randomized self-checking bench for ram_arbiter against a transaction-level model.
module tb_ram_arbiter;
    localparam int LAT = 3;
    localparam int SM = 8;
    localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic i_req_valid, i_req_ready, i_resp_valid, i_resp_ready;
    logic [63:0] i_addr;
    logic [31:0] i_inst;
    logic d_req_valid, d_req_ready, d_we, d_resp_valid, d_resp_ready;
    logic [63:0] d_addr, d_wdata, d_wmask, d_rdata;
    logic [63:0] mem_addr, mem_w_data, mem_w_mask, mem_r_data;
    logic mem_r_ena, mem_w_ena;

    int checks = 0;
    int errors = 0;
    logic [63:0] ram [256];
    logic [63:0] exp_mem [256];
    logic [63:0] pipe [LAT];
    bit inited = 1'b0;
    int starve = 0;
    bit last_d = 1'b0;

    always #5 clk = ~clk;

    ram_arbiter #(.RAM_BASE(BASE), .RAM_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_addr(i_addr),
        .i_resp_valid(i_resp_valid), .i_resp_ready(i_resp_ready), .i_inst(i_inst),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_we(d_we), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_wmask(d_wmask), .d_resp_valid(d_resp_valid),
        .d_resp_ready(d_resp_ready), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_r_ena(mem_r_ena), .mem_w_ena(mem_w_ena),
        .mem_w_data(mem_w_data), .mem_w_mask(mem_w_mask), .mem_r_data(mem_r_data)
    );

    assign mem_r_data = pipe[LAT-1];

    function automatic logic [63:0] init_word(int k);
        return k == 0 ? 64'hAAAA_BBBB_CCCC_DDDD : {32'(k) * 32'h9E37_79B9, ~32'(k) ^ 32'h5A5A_1234};
    endfunction

    // RAM helper model: read data appears LAT cycles after mem_r_ena, random noise otherwise.
    always @(posedge clk) begin
        if (!inited) begin
            for (int k = 0; k < 256; k++) ram[k] <= init_word(k);
            inited <= 1'b1;
        end else if (mem_w_ena) begin
            ram[mem_addr[7:0]] <= (ram[mem_addr[7:0]] & ~mem_w_mask) | (mem_w_data & mem_w_mask);
        end
        for (int k = LAT - 1; k > 0; k--) pipe[k] <= pipe[k-1];
        pipe[0] <= mem_r_ena ? ram[mem_addr[7:0]] : {$urandom, $urandom};
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic bit i_pref();
`ifdef ARB_ROUND_ROBIN_EN
        return last_d;
`else
        return starve >= SM;
`endif
    endfunction

    function automatic logic [63:0] raddr(bit is_i);
        logic [63:0] off;
        off = 64'($urandom_range(0, 255)) << 3;
        return BASE + off + (is_i ? 64'($urandom_range(0, 1)) << 2 : 64'($urandom_range(0, 7)));
    endfunction

    // One full transaction, starting just after a rising edge with the DUT idle.
    task automatic txn(input bit vi, input bit vd, input bit we, input logic [63:0] ia,
                       input logic [63:0] da, input logic [63:0] wd, input logic [63:0] wm,
                       input int hold);
        bit gd, st;
        logic [63:0] a, expv;
        logic [7:0] idx;
        int lat;
        gd = vd && !(vi && i_pref());
        st = gd && we;
        a = (gd ? da : ia) - BASE;
        idx = a[10:3];
        i_req_valid = vi; i_addr = ia;
        d_req_valid = vd; d_we = we; d_addr = da; d_wdata = wd; d_wmask = wm;
        i_resp_ready = gd; d_resp_ready = !gd;
        @(negedge clk);
        chk("i_req_ready", 64'(i_req_ready), 64'(!gd));
        chk("d_req_ready", 64'(d_req_ready), 64'(gd));
        chk("mem_addr", mem_addr, a >> 3);
        chk("mem_r_ena", 64'(mem_r_ena), 64'(!st));
        chk("mem_w_ena", 64'(mem_w_ena), 64'(st));
        if (st) begin
            chk("mem_w_data", mem_w_data, wd);
            chk("mem_w_mask", mem_w_mask, wm);
        end
`ifdef ARB_ROUND_ROBIN_EN
        last_d = gd;
`else
        starve = gd ? (vi ? starve + 1 : starve) : 0;
`endif
        if (st) begin
            expv = 64'd0;
            exp_mem[idx] = (exp_mem[idx] & ~wm) | (wd & wm);
        end else if (gd) begin
            expv = exp_mem[idx];
        end else begin
            expv = 64'(ia[2] ? exp_mem[idx][63:32] : exp_mem[idx][31:0]);
        end
        lat = st ? 1 : LAT + 1;
        for (int c = 1; c <= lat + hold; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("busy_ready", 64'({i_req_ready, d_req_ready}), 64'd0);
            chk("busy_ena", 64'({mem_r_ena, mem_w_ena}), 64'd0);
            chk("i_resp_valid", 64'(i_resp_valid), 64'(c >= lat && !gd));
            chk("d_resp_valid", 64'(d_resp_valid), 64'(c >= lat && gd));
            if (c >= lat) chk("resp_data", gd ? d_rdata : 64'(i_inst), expv);
        end
        i_resp_ready = !gd; d_resp_ready = gd;
        @(posedge clk); #1;
        i_req_valid = 1'b0; d_req_valid = 1'b0; i_resp_ready = 1'b0; d_resp_ready = 1'b0;
        @(negedge clk);
        chk("post_hs_valid", 64'({i_resp_valid, d_resp_valid}), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        bit vi, vd;
        i_req_valid = 1'b0; i_addr = '0; i_resp_ready = 1'b0;
        d_req_valid = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wmask = '0; d_resp_ready = 1'b0;
        for (int k = 0; k < 256; k++) exp_mem[k] = init_word(k);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 64'({i_req_ready, d_req_ready}), 64'd0);
        chk("rst_resp_valid", 64'({i_resp_valid, d_resp_valid}), 64'd0);
        chk("rst_i_inst", 64'(i_inst), 64'd0);
        chk("rst_d_rdata", d_rdata, 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_ena", 64'({mem_r_ena, mem_w_ena}), 64'd0);
        chk("rst_w_data", mem_w_data, 64'd0);
        chk("rst_w_mask", mem_w_mask, 64'd0);
        i_req_valid = 1'b1; d_req_valid = 1'b1;
        #1;
        chk("rst_ready_valids_high", 64'({i_req_ready, d_req_ready}), 64'd0);
        chk("rst_ena_valids_high", 64'({mem_r_ena, mem_w_ena}), 64'd0);
        i_req_valid = 1'b0; d_req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        txn(1, 0, 0, BASE + 64'h4, '0, '0, '0, 0);
        txn(1, 0, 0, BASE, '0, '0, '0, 0);
        txn(0, 1, 1, '0, BASE + 64'h10, 64'h1122_3344_5566_7788, 64'hFFFF_FFFF_0000_0000, 0);
        txn(0, 1, 0, '0, BASE + 64'h10, '0, '0, 0);
        txn(0, 1, 1, '0, BASE - 64'h8, 64'hDEAD_BEEF_0BAD_F00D, 64'h0000_FFFF_FFFF_0000, 1);
        txn(0, 1, 0, '0, BASE - 64'h8, '0, '0, 0);
        txn(1, 0, 0, BASE + 64'h44, '0, '0, '0, 5);
        txn(0, 1, 0, '0, BASE + 64'h20, '0, '0, 0);

        for (int n = 0; n < 20; n++) txn(1, 1, 0, raddr(1), raddr(0), '0, '0, 0);

        for (int n = 0; n < 40; n++) begin
            vi = 1'($urandom_range(0, 1));
            vd = vi ? 1'($urandom_range(0, 1)) : 1'b1;
            txn(vi, vd, 1'($urandom_range(0, 1)), raddr(1), raddr(0), {$urandom, $urandom},
                {$urandom, $urandom}, int'($urandom_range(0, 2)));
        end

        i_req_valid = 1'b1; i_addr = BASE + 64'h28;
        @(negedge clk);
        chk("pre_rst_grant", 64'(i_req_ready), 64'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 64'({i_req_ready, d_req_ready}), 64'd0);
        chk("mid_rst_ena", 64'({mem_r_ena, mem_w_ena}), 64'd0);
        chk("mid_rst_resp_valid", 64'({i_resp_valid, d_resp_valid}), 64'd0);
        i_req_valid = 1'b0;
        starve = 0; last_d = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < LAT + 2; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("stale_resp", 64'({i_resp_valid, d_resp_valid}), 64'd0);
        end
        @(posedge clk); #1;
        for (int n = 0; n < 10; n++) txn(1, 1, 0, raddr(1), raddr(0), '0, '0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
